coin_collector: RTL and testbench

Front-end coin stage for the drink vending machine. It synchronises and debounces the raw half-dollar and one-dollar coin sensor lines, and accumulates the coins of one customer transaction. It closes the transaction after an idle timeout and presents the totals to the `drink` controller as `half_dollar`/`one_dollar` counts, qualified by a one-cycle `ena`. It also handles customer cancel (refund) and over-capacity coins (reject).

---
 rtl/coin_collector.sv | 231 +++++++++++++++++++++++
 tb/tb_coin_collector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_collector.sv
// coin_collector: coin front end for the drink vending machine.
// Synchronises and debounces the two raw coin sensors, accumulates the
// coins of one customer transaction and hands the totals to the drink
// controller after an idle timeout. Also handles cancel (refund) and
// coins that cannot be accepted (reject).

// CoinDebounce: 2-flop synchroniser followed by a saturating debounce
// counter. Emits a single-cycle qualify pulse per sufficiently long high
// period of the raw sensor line.
module CoinDebounce #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic coin_i,
  output logic qualify_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          synced;

  assign synced = sync_q[1];

  // Two-stage synchroniser for the asynchronous sensor line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], coin_i};
    end
  end

  // Debounce count: climbs while the line is high, parks at DEBOUNCE, clears on low.
  always_comb begin
    cnt_d = cnt_q;
    if (!synced) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The coin qualifies on the edge where the count reaches DEBOUNCE, so the
  // consumer updates on that same edge; the parked count blocks repeats.
  assign qualify_o = synced && (cnt_q == DEB_LAST);

endmodule

// Top level: transaction FSM and coin accounting.
module coin_collector #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_half_in,
  input  logic       coin_one_in,
  input  logic       cancel,
  output logic [1:0] half_dollar,
  output logic [1:0] one_dollar,
  output logic       ena,
  output logic       refund,
  output logic       reject,
  output logic [1:0] state
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    COUNT_MAX  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    REFUND  = 2'd3
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [1:0]    halfCount_q;
  logic [1:0]    halfCount_d;
  logic [1:0]    oneCount_q;
  logic [1:0]    oneCount_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          reject_q;
  logic          reject_d;
  logic          ena_q;
  logic          ena_d;
  logic          refund_q;
  logic          refund_d;
  logic          counted;
  logic          qualHalf;
  logic          qualOne;

  CoinDebounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debHalf (
    .clk_i     (clk),
    .rst_ni    (reset),
    .coin_i    (coin_half_in),
    .qualify_o (qualHalf)
  );

  CoinDebounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debOne (
    .clk_i     (clk),
    .rst_ni    (reset),
    .coin_i    (coin_one_in),
    .qualify_o (qualOne)
  );

  // Next-state, count, timer and strobe logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    halfCount_d = halfCount_q;
    oneCount_d  = oneCount_q;
    timer_d     = timer_q;
    reject_d    = 1'b0;
    counted     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (qualHalf) begin
          halfCount_d = 2'd1;
        end
        if (qualOne) begin
          oneCount_d = 2'd1;
        end
        if (qualHalf || qualOne) begin
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (qualHalf) begin
          if (halfCount_q != COUNT_MAX) begin
            halfCount_d = halfCount_q + 2'd1;
            counted     = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
        if (qualOne) begin
          if (oneCount_q != COUNT_MAX) begin
            oneCount_d = oneCount_q + 2'd1;
            counted    = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
        // A rejected coin does not count as activity, so it does not restart the timer.
        if (counted) begin
          timer_d = '0;
        end else if (timer_q != TIMER_LAST) begin
          timer_d = timer_q + 1'b1;
        end
        // Cancel beats timeout when both land in the same cycle.
        if (cancel) begin
          state_d = REFUND;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ISSUE;
        end
      end

      ISSUE, REFUND: begin
        reject_d    = qualHalf || qualOne;
        state_d     = IDLE;
        halfCount_d = 2'd0;
        oneCount_d  = 2'd0;
        timer_d     = '0;
      end

      default: begin
        state_d     = IDLE;
        halfCount_d = 2'd0;
        oneCount_d  = 2'd0;
        timer_d     = '0;
      end
    endcase

    ena_d    = (state_d == ISSUE);
    refund_d = (state_d == REFUND);
  end

  // State, count, timer and output strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      halfCount_q <= 2'd0;
      oneCount_q  <= 2'd0;
      timer_q     <= '0;
      reject_q    <= 1'b0;
      ena_q       <= 1'b0;
      refund_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      halfCount_q <= halfCount_d;
      oneCount_q  <= oneCount_d;
      timer_q     <= timer_d;
      reject_q    <= reject_d;
      ena_q       <= ena_d;
      refund_q    <= refund_d;
    end
  end

  assign half_dollar = halfCount_q;
  assign one_dollar  = oneCount_q;
  assign ena         = ena_q;
  assign refund      = refund_q;
  assign reject      = reject_q;
  assign state       = state_q;

endmodule

// File: tb/tb_coin_collector.sv
// Testbench for coin_collector: table of coin-pulse records plus
// hand-written sequences for timeout, cancel and reset corner cases.
module tb_coin_collector;

  logic       clk;
  logic       reset;
  logic       coinHalfIn;
  logic       coinOneIn;
  logic       cancelIn;
  logic [1:0] halfDollar;
  logic [1:0] oneDollar;
  logic       ena;
  logic       refund;
  logic       reject;
  logic [1:0] state;

  int total;
  int bad;
  int rejSeen;
  int enaSeen;
  int refSeen;

  typedef struct {
    int halfW;
    int oneW;
    int gap;
    int expHalf;
    int expOne;
    int expState;
    int expRej;
    int expEna;
  } vec_t;

  vec_t vecs[9];

  coin_collector #(
    .DEBOUNCE (3),
    .TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_half_in (coinHalfIn),
    .coin_one_in  (coinOneIn),
    .cancel       (cancelIn),
    .half_dollar  (halfDollar),
    .one_dollar   (oneDollar),
    .ena          (ena),
    .refund       (refund),
    .reject       (reject),
    .state        (state)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock, then sample 1 unit after the edge and tally the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reject) rejSeen++;
    if (ena) enaSeen++;
    if (refund) refSeen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearSeen();
    rejSeen = 0;
    enaSeen = 0;
    refSeen = 0;
  endtask

  // Drive one table record: pulse widths on each line, then a low gap.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n;
    n = ((v.halfW > v.oneW) ? v.halfW : v.oneW) + v.gap;
    clearSeen();
    for (int i = 0; i < n; i++) begin
      coinHalfIn = (i < v.halfW);
      coinOneIn  = (i < v.oneW);
      tick();
    end
    coinHalfIn = 1'b0;
    coinOneIn  = 1'b0;
    checkOutput($sformatf("vec%0d half", idx), int'(halfDollar), v.expHalf);
    checkOutput($sformatf("vec%0d one", idx), int'(oneDollar), v.expOne);
    checkOutput($sformatf("vec%0d state", idx), int'(state), v.expState);
    checkOutput($sformatf("vec%0d rejects", idx), rejSeen, v.expRej);
    checkOutput($sformatf("vec%0d enas", idx), enaSeen, v.expEna);
  endtask

  // Main test sequence.
  initial begin
    total = 0;
    bad = 0;
    clearSeen();
    coinHalfIn = 1'b0;
    coinOneIn  = 1'b0;
    cancelIn   = 1'b0;
    reset      = 1'b1;

    vecs[0] = '{halfW:0, oneW:1, gap:4, expHalf:0, expOne:0, expState:0, expRej:0, expEna:0};
    vecs[1] = '{halfW:0, oneW:2, gap:4, expHalf:0, expOne:0, expState:0, expRej:0, expEna:0};
    vecs[2] = '{halfW:0, oneW:3, gap:4, expHalf:0, expOne:1, expState:1, expRej:0, expEna:0};
    vecs[3] = '{halfW:0, oneW:6, gap:6, expHalf:0, expOne:2, expState:1, expRej:0, expEna:0};
    vecs[4] = '{halfW:0, oneW:6, gap:6, expHalf:0, expOne:3, expState:1, expRej:0, expEna:0};
    vecs[5] = '{halfW:0, oneW:6, gap:6, expHalf:0, expOne:0, expState:0, expRej:1, expEna:1};
    vecs[6] = '{halfW:6, oneW:6, gap:6, expHalf:1, expOne:1, expState:1, expRej:0, expEna:0};
    vecs[7] = '{halfW:6, oneW:0, gap:6, expHalf:2, expOne:1, expState:1, expRej:0, expEna:0};
    vecs[8] = '{halfW:0, oneW:6, gap:6, expHalf:2, expOne:2, expState:1, expRej:0, expEna:0};

    // Reset held for 5 cycles while the coin lines toggle.
    #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      coinHalfIn = ~coinHalfIn;
      coinOneIn  = (i % 2) == 0;
      tick();
    end
    checkOutput("reset state", int'(state), 0);
    checkOutput("reset half", int'(halfDollar), 0);
    checkOutput("reset one", int'(oneDollar), 0);
    checkOutput("reset strobes", int'({ena, refund, reject}), 0);
    coinHalfIn = 1'b0;
    coinOneIn  = 1'b0;
    tick();
    reset = 1'b1;
    clearSeen();
    ticks(10);
    checkOutput("post-reset strobes", rejSeen + enaSeen + refSeen, 0);
    checkOutput("post-reset state", int'(state), 0);
    checkOutput("post-reset counts", int'({halfDollar, oneDollar}), 0);

    // Table: debounce glitches, saturation with timeout, simultaneous coins.
    for (int v = 0; v < 9; v++) applyStimulus(vecs[v], v);

    // Cancel from 2/2 in COLLECT.
    clearSeen();
    cancelIn = 1'b1;
    tick();
    cancelIn = 1'b0;
    checkOutput("cancel refund", int'(refund), 1);
    checkOutput("cancel state", int'(state), 3);
    checkOutput("cancel half held", int'(halfDollar), 2);
    checkOutput("cancel one held", int'(oneDollar), 2);
    tick();
    checkOutput("after cancel state", int'(state), 0);
    checkOutput("after cancel counts", int'({halfDollar, oneDollar}), 0);
    checkOutput("after cancel refund", int'(refund), 0);
    ticks(20);
    checkOutput("cancel no ena", enaSeen, 0);
    checkOutput("cancel one refund", refSeen, 1);

    // Coin latency and exact issue timing.
    clearSeen();
    coinHalfIn = 1'b1;
    ticks(4);
    checkOutput("latency early", int'(halfDollar), 0);
    tick();
    checkOutput("latency on time", int'(halfDollar), 1);
    checkOutput("latency state", int'(state), 1);
    coinHalfIn = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 15) begin
        checkOutput("issue k15 ena", int'(ena), 0);
        checkOutput("issue k15 state", int'(state), 1);
      end else if (k == 16) begin
        checkOutput("issue k16 ena", int'(ena), 1);
        checkOutput("issue k16 state", int'(state), 2);
        checkOutput("issue k16 half", int'(halfDollar), 1);
      end else if (k == 17) begin
        checkOutput("issue k17 ena", int'(ena), 0);
        checkOutput("issue k17 half", int'(halfDollar), 0);
        checkOutput("issue k17 state", int'(state), 0);
      end
    end
    checkOutput("issue ena count", enaSeen, 1);

    // Cancel landing on the timeout cycle: refund wins.
    clearSeen();
    coinOneIn = 1'b1;
    ticks(5);
    checkOutput("tocancel one", int'(oneDollar), 1);
    coinOneIn = 1'b0;
    ticks(15);
    cancelIn = 1'b1;
    tick();
    cancelIn = 1'b0;
    checkOutput("tocancel refund", int'(refund), 1);
    checkOutput("tocancel ena", int'(ena), 0);
    checkOutput("tocancel state", int'(state), 3);
    checkOutput("tocancel one held", int'(oneDollar), 1);
    tick();
    checkOutput("tocancel idle", int'(state), 0);
    ticks(20);
    checkOutput("tocancel no ena", enaSeen, 0);

    // Reset mid-transaction with counts 1/1.
    coinHalfIn = 1'b1;
    coinOneIn  = 1'b1;
    ticks(5);
    coinHalfIn = 1'b0;
    coinOneIn  = 1'b0;
    checkOutput("midreset pre counts", int'({halfDollar, oneDollar}), 5);
    ticks(3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset async state", int'(state), 0);
    checkOutput("midreset async counts", int'({halfDollar, oneDollar}), 0);
    tick();
    reset = 1'b1;
    clearSeen();
    ticks(20);
    checkOutput("midreset no ena", enaSeen, 0);
    checkOutput("midreset no refund", refSeen, 0);
    checkOutput("midreset final state", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
